// File: rtl/wb_arbiter_swc_pkg.sv
// Shared types and helpers for the writeback arbiter: load-type codes,
// the load tracking entry and the load data extract/extend function.
package swc_wb_pkg;

    localparam int LD_DEPTH_DEF = 2;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic [4:0] rd;
        logic [2:0] funct3;
        logic [1:0] offset;
    } ld_entry_t;

    function automatic logic is_subword(input logic [2:0] f3);
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

    // Sub-word loads only: result is 32 bits with its sign already in bit 31,
    // so callers can widen it with a signed cast.
    function automatic logic [31:0] ld_extend(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            F3_LB:   r = {{24{b[7]}}, b};
            F3_LBU:  r = {24'h0, b};
            F3_LH:   r = {{16{h[15]}}, h};
            F3_LHU:  r = {16'h0, h};
            default: r = w;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/wb_arbiter_swc_ld_fifo.sv
// In-order tracking FIFO for outstanding loads; push is ignored when full,
// pop is ignored when empty.
module wb_ld_fifo
    import swc_wb_pkg::*;
#(
    parameter int DEPTH = LD_DEPTH_DEF
) (
    input  logic      hclk,
    input  logic      hrstn,
    input  logic      push,
    input  ld_entry_t din,
    input  logic      pop,
    output ld_entry_t dout,
    output logic      full,
    output logic      empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    ld_entry_t       mem [DEPTH];
    logic [AW-1:0]   wptr, rptr;
    logic [CW-1:0]   count;
    logic            do_push, do_pop;

    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rptr];

    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= inc(wptr);
            if (do_pop)  rptr <= inc(rptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge hclk) begin
        if (do_push) mem[wptr] <= din;
    end

endmodule

// File: rtl/wb_arbiter_swc.sv
// Writeback arbiter: merges ALU results and in-order load responses onto the
// single regfile write port and tracks destinations of outstanding loads.
module wb_arbiter_swc
    import swc_wb_pkg::*;
#(
    parameter int LD_DEPTH = LD_DEPTH_DEF,
    parameter int XLEN     = 32
) (
    input  logic            hclk,
    input  logic            hrstn,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            ld_req_valid,
    output logic            ld_req_ready,
    input  logic [4:0]      ld_rd,
    input  logic [2:0]      ld_funct3,
    input  logic [1:0]      ld_offset,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [4:0]      reg_waddr,
    output logic [XLEN-1:0] reg_wdata,
    output logic            reg_wen,
    output logic [31:0]     pending_mask,
    output logic            wb_err
);

    ld_entry_t       head, push_entry;
    logic            fifo_full, fifo_empty;
    logic            ld_push, ld_pop, alu_fire;
    logic [XLEN-1:0] ld_data;
    logic [31:0]     pending_nxt;

    assign push_entry   = '{rd: ld_rd, funct3: ld_funct3, offset: ld_offset};
    assign ld_req_ready = ~fifo_full & ~((ld_rd != 5'd0) & pending_mask[ld_rd]);
    assign ld_push      = ld_req_valid & ld_req_ready;
    assign ld_pop       = mem_rvalid & ~fifo_empty;
    // Load responses cannot be stalled, so they always take the port; the
    // pending check keeps an ALU write from being overtaken by an older load.
    assign alu_ready    = ~mem_rvalid & ~((alu_rd != 5'd0) & pending_mask[alu_rd]);
    assign alu_fire     = alu_valid & alu_ready;

    wb_ld_fifo #(.DEPTH(LD_DEPTH)) u_ld_fifo (
        .hclk  (hclk),
        .hrstn (hrstn),
        .push  (ld_push),
        .din   (push_entry),
        .pop   (ld_pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        ld_data = mem_rdata;
        if (is_subword(head.funct3))
            ld_data = XLEN'($signed(ld_extend(head.funct3, head.offset, mem_rdata[31:0])));
    end

    always_comb begin
        pending_nxt = pending_mask;
        if (ld_pop && head.rd != 5'd0)   pending_nxt[head.rd] = 1'b0;
        if (ld_push && ld_rd != 5'd0)    pending_nxt[ld_rd]   = 1'b1;
    end

    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            reg_wen      <= 1'b0;
            reg_waddr    <= '0;
            reg_wdata    <= '0;
            pending_mask <= '0;
            wb_err       <= 1'b0;
        end else begin
            reg_wen      <= 1'b0;
            pending_mask <= pending_nxt;
            if (ld_pop) begin
                if (head.rd != 5'd0) begin
                    reg_wen   <= 1'b1;
                    reg_waddr <= head.rd;
                    reg_wdata <= ld_data;
                end
            end else if (alu_fire && alu_rd != 5'd0) begin
                reg_wen   <= 1'b1;
                reg_waddr <= alu_rd;
                reg_wdata <= alu_data;
            end
            if (mem_rvalid && fifo_empty) wb_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_arbiter_swc.sv
// Directed bench for wb_arbiter_swc: a per-cycle vector table followed by a
// hand-written asynchronous reset sequence.
module tb_wb_arbiter_swc;

    logic        hclk = 1'b0;
    logic        hrstn;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_req_valid, ld_req_ready;
    logic [4:0]  ld_rd;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_offset;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [4:0]  reg_waddr;
    logic [31:0] reg_wdata;
    logic        reg_wen;
    logic [31:0] pending_mask;
    logic        wb_err;

    int checks = 0;
    int errors = 0;

    wb_arbiter_swc #(.LD_DEPTH(2), .XLEN(32)) dut (
        .hclk         (hclk),
        .hrstn        (hrstn),
        .alu_valid    (alu_valid),
        .alu_ready    (alu_ready),
        .alu_rd       (alu_rd),
        .alu_data     (alu_data),
        .ld_req_valid (ld_req_valid),
        .ld_req_ready (ld_req_ready),
        .ld_rd        (ld_rd),
        .ld_funct3    (ld_funct3),
        .ld_offset    (ld_offset),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .reg_waddr    (reg_waddr),
        .reg_wdata    (reg_wdata),
        .reg_wen      (reg_wen),
        .pending_mask (pending_mask),
        .wb_err       (wb_err)
    );

    always #5 hclk = ~hclk;

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adat;
        logic        lv;
        logic [4:0]  lrd;
        logic [2:0]  lf3;
        logic [1:0]  loff;
        logic        mv;
        logic [31:0] mdat;
        logic        e_ar;
        logic        e_lr;
        logic        e_wen;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        logic [31:0] e_pm;
        logic        e_err;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        ld_req_valid = 0; ld_rd = 0; ld_funct3 = 0; ld_offset = 0;
        mem_rvalid = 0; mem_rdata = 0;
    endtask

    task automatic apply(input vec_t v);
        alu_valid = v.av; alu_rd = v.ard; alu_data = v.adat;
        ld_req_valid = v.lv; ld_rd = v.lrd; ld_funct3 = v.lf3; ld_offset = v.loff;
        mem_rvalid = v.mv; mem_rdata = v.mdat;
    endtask

    initial begin
        //            av ard   adat          lv lrd   f3    off   mv mdat          ar lr wen wa    wd            pm            err
        tbl.push_back('{1, 5'd5, 32'h12345678, 0, 5'd0, 3'd0, 2'd0, 0, 32'h0,        1, 1, 1, 5'd5, 32'h12345678, 32'h0,        0}); // ALU write
        tbl.push_back('{0, 5'd0, 32'h0,        0, 5'd0, 3'd0, 2'd0, 0, 32'h0,        1, 1, 0, 5'd5, 32'h12345678, 32'h0,        0}); // hold
        tbl.push_back('{0, 5'd0, 32'h0,        1, 5'd1, 3'd0, 2'd3, 0, 32'h0,        1, 1, 0, 5'd5, 32'h12345678, 32'h2,        0}); // LB x1 off3
        tbl.push_back('{0, 5'd0, 32'h0,        0, 5'd0, 3'd0, 2'd0, 1, 32'h80FF0000, 0, 1, 1, 5'd1, 32'hFFFFFF80, 32'h0,        0});
        tbl.push_back('{0, 5'd0, 32'h0,        1, 5'd2, 3'd5, 2'd2, 0, 32'h0,        1, 1, 0, 5'd1, 32'hFFFFFF80, 32'h4,        0}); // LHU x2 off2
        tbl.push_back('{0, 5'd0, 32'h0,        0, 5'd0, 3'd0, 2'd0, 1, 32'h80FF0000, 0, 1, 1, 5'd2, 32'h000080FF, 32'h0,        0});
        tbl.push_back('{0, 5'd0, 32'h0,        1, 5'd3, 3'd2, 2'd0, 0, 32'h0,        1, 1, 0, 5'd2, 32'h000080FF, 32'h8,        0}); // LW x3
        tbl.push_back('{1, 5'd9, 32'hAAAA5555, 0, 5'd0, 3'd0, 2'd0, 1, 32'h80FF0000, 0, 1, 1, 5'd3, 32'h80FF0000, 32'h0,        0}); // conflict: load wins
        tbl.push_back('{1, 5'd9, 32'hAAAA5555, 0, 5'd0, 3'd0, 2'd0, 0, 32'h0,        1, 1, 1, 5'd9, 32'hAAAA5555, 32'h0,        0}); // ALU next cycle
        tbl.push_back('{0, 5'd0, 32'h0,        1, 5'd7, 3'd2, 2'd0, 0, 32'h0,        1, 1, 0, 5'd9, 32'hAAAA5555, 32'h80,       0}); // LW x7
        tbl.push_back('{1, 5'd7, 32'h77777777, 0, 5'd0, 3'd0, 2'd0, 0, 32'h0,        0, 1, 0, 5'd9, 32'hAAAA5555, 32'h80,       0}); // WAW stall
        tbl.push_back('{1, 5'd7, 32'h77777777, 0, 5'd0, 3'd0, 2'd0, 1, 32'h11223344, 0, 1, 1, 5'd7, 32'h11223344, 32'h0,        0});
        tbl.push_back('{1, 5'd7, 32'h77777777, 0, 5'd0, 3'd0, 2'd0, 0, 32'h0,        1, 1, 1, 5'd7, 32'h77777777, 32'h0,        0});
        tbl.push_back('{0, 5'd0, 32'h0,        1, 5'd4, 3'd0, 2'd0, 0, 32'h0,        1, 1, 0, 5'd7, 32'h77777777, 32'h10,       0}); // LB x4
        tbl.push_back('{0, 5'd0, 32'h0,        1, 5'd5, 3'd1, 2'd1, 0, 32'h0,        1, 1, 0, 5'd7, 32'h77777777, 32'h30,       0}); // LH x5 off1
        tbl.push_back('{0, 5'd0, 32'h0,        1, 5'd6, 3'd2, 2'd0, 0, 32'h0,        1, 0, 0, 5'd7, 32'h77777777, 32'h30,       0}); // full
        tbl.push_back('{0, 5'd0, 32'h0,        1, 5'd6, 3'd2, 2'd0, 1, 32'h00008001, 0, 0, 1, 5'd4, 32'h00000001, 32'h20,       0}); // pop while full
        tbl.push_back('{0, 5'd0, 32'h0,        1, 5'd6, 3'd2, 2'd0, 1, 32'h00008001, 0, 1, 1, 5'd5, 32'hFFFF8001, 32'h40,       0}); // push+pop
        tbl.push_back('{0, 5'd0, 32'h0,        0, 5'd0, 3'd0, 2'd0, 1, 32'hDEADBEEF, 0, 1, 1, 5'd6, 32'hDEADBEEF, 32'h0,        0});
        tbl.push_back('{0, 5'd0, 32'h0,        1, 5'd0, 3'd2, 2'd0, 0, 32'h0,        1, 1, 0, 5'd6, 32'hDEADBEEF, 32'h0,        0}); // load to x0
        tbl.push_back('{0, 5'd0, 32'h0,        0, 5'd0, 3'd0, 2'd0, 1, 32'h12121212, 0, 1, 0, 5'd6, 32'hDEADBEEF, 32'h0,        0});
        tbl.push_back('{1, 5'd0, 32'h00000005, 0, 5'd0, 3'd0, 2'd0, 0, 32'h0,        1, 1, 0, 5'd6, 32'hDEADBEEF, 32'h0,        0}); // ALU to x0
        tbl.push_back('{0, 5'd0, 32'h0,        1, 5'd8, 3'd2, 2'd0, 0, 32'h0,        1, 1, 0, 5'd6, 32'hDEADBEEF, 32'h100,      0}); // LW x8
        tbl.push_back('{0, 5'd0, 32'h0,        1, 5'd8, 3'd2, 2'd0, 0, 32'h0,        1, 0, 0, 5'd6, 32'hDEADBEEF, 32'h100,      0}); // same rd refused
        tbl.push_back('{0, 5'd0, 32'h0,        0, 5'd0, 3'd0, 2'd0, 1, 32'hCAFEF00D, 0, 1, 1, 5'd8, 32'hCAFEF00D, 32'h0,        0});
        tbl.push_back('{0, 5'd0, 32'h0,        0, 5'd0, 3'd0, 2'd0, 1, 32'h00000055, 0, 1, 0, 5'd8, 32'hCAFEF00D, 32'h0,        1}); // stray rvalid
        tbl.push_back('{0, 5'd0, 32'h0,        0, 5'd0, 3'd0, 2'd0, 0, 32'h0,        1, 1, 0, 5'd8, 32'hCAFEF00D, 32'h0,        1}); // sticky

        drive_idle();
        hrstn = 0;
        repeat (2) @(posedge hclk);
        #1;
        check("reset_state", {reg_wen, reg_waddr, reg_wdata, pending_mask, wb_err},
              {1'b0, 5'd0, 32'h0, 32'h0, 1'b0});
        @(negedge hclk);
        hrstn = 1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge hclk);
            apply(tbl[i]);
            #1;
            check($sformatf("ready[%0d]", i), {alu_ready, ld_req_ready}, {tbl[i].e_ar, tbl[i].e_lr});
            @(posedge hclk);
            #1;
            check($sformatf("wb[%0d]", i), {reg_wen, reg_waddr, reg_wdata, pending_mask, wb_err},
                  {tbl[i].e_wen, tbl[i].e_wa, tbl[i].e_wd, tbl[i].e_pm, tbl[i].e_err});
        end

        // Two loads outstanding and a write in flight, then async reset.
        @(negedge hclk);
        drive_idle();
        ld_req_valid = 1; ld_rd = 5'd10; ld_funct3 = 3'd0;
        @(negedge hclk);
        ld_rd = 5'd11;
        @(negedge hclk);
        drive_idle();
        alu_valid = 1; alu_rd = 5'd12; alu_data = 32'h0BADF00D;
        @(posedge hclk);
        #1;
        check("pre_reset", {reg_wen, reg_waddr, reg_wdata, pending_mask},
              {1'b1, 5'd12, 32'h0BADF00D, 32'h00000C00});
        #1;
        hrstn = 0;
        #1;
        check("async_reset", {reg_wen, reg_waddr, reg_wdata, pending_mask, wb_err},
              {1'b0, 5'd0, 32'h0, 32'h0, 1'b0});
        @(negedge hclk);
        drive_idle();
        hrstn = 1;
        @(negedge hclk);
        mem_rvalid = 1; mem_rdata = 32'h11111111;
        @(posedge hclk);
        #1;
        check("rvalid_after_reset", {reg_wen, pending_mask, wb_err}, {1'b0, 32'h0, 1'b1});
        @(negedge hclk);
        drive_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
